// File: rtl/ir_rx_pkg.sv
// Shared definitions for the IR rangefinder frame parser: FSM states,
// ASCII digit bounds and flag_tu_ao encodings.
package ir_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GOT_H0 = 2'd1,
        ST_GOT_H1 = 2'd2,
        ST_DIGITS = 2'd3
    } rx_state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    localparam logic [1:0] FLAG_BUMP = 2'b10;
    localparam logic [1:0] FLAG_DIP  = 2'b01;
    localparam logic [1:0] FLAG_FLAT = 2'b00;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/ir_range_frame_parser_if.sv
// Byte-in / distance-out bundle of the IR rangefinder frame parser.
// master: the side feeding UART bytes and consuming results.
// slave : the parser itself.
interface ir_range_frame_parser_if #(
    parameter int DIST_W = 10
) ();

    logic [7:0]        rx_data;
    logic              rx_int;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic              frame_err;
    logic [1:0]        flag_tu_ao;

    modport master (
        output rx_data,
        output rx_int,
        input  distance,
        input  dist_valid,
        input  frame_err,
        input  flag_tu_ao
    );

    modport slave (
        input  rx_data,
        input  rx_int,
        output distance,
        output dist_valid,
        output frame_err,
        output flag_tu_ao
    );

endinterface

// File: rtl/ir_persist_filter.sv
// Window compare plus saturating consecutive-hit counter.
// hit reflects the count the register takes at the coming edge, so a
// downstream register sampling hit lines up with the counter update.
module ir_persist_filter #(
    parameter int LO  = 0,
    parameter int HI  = 0,
    parameter int CNT = 1,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         upd,
    input  logic         clr,
    input  logic [W-1:0] value,
    output logic         hit
);

    localparam int              CW    = $clog2(CNT + 1);
    localparam logic [CW-1:0]   CNT_V = CW'(CNT);
    localparam logic [31:0]     LO32  = 32'(LO);
    localparam logic [31:0]     HI32  = 32'(HI);

    logic [31:0]   val32;
    logic          in_win;
    logic [CW-1:0] cnt_p0;
    logic [CW-1:0] cnt_nxt;

    // Window bounds are compared at 32 bits so bounds above 2**W-1 keep their meaning.
    assign val32  = 32'(value);
    assign in_win = (val32 >= LO32) && (val32 <= HI32);

    // Next count: clear wins, a window hit saturates upward, a miss restarts.
    always_comb begin
        cnt_nxt = cnt_p0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (upd) begin
            if (!in_win)
                cnt_nxt = '0;
            else if (cnt_p0 != CNT_V)
                cnt_nxt = cnt_p0 + CW'(1);
        end
    end

    assign hit = (cnt_nxt == CNT_V);

    // Persistence counter register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_p0 <= '0;
        else
            cnt_p0 <= cnt_nxt;
    end

endmodule

// File: rtl/ir_range_frame_parser.sv
// IR rangefinder frame parser: turns "<HDR0><HDR1><HDR2><digits>" byte
// streams from uart_rx into a saturated binary distance and a bump/dip/flat
// classification with consecutive-frame persistence.
// Optional feature: define IR_RX_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYC clocks without a byte (also clears the persistence state).
module ir_range_frame_parser
    import ir_rx_pkg::*;
#(
    parameter logic [7:0] HDR0        = 8'h41,
    parameter logic [7:0] HDR1        = 8'h42,
    parameter logic [7:0] HDR2        = 8'h43,
    parameter int         NUM_DIGITS  = 3,
    parameter int         DIST_W      = 10,
    parameter int         DIP_LO      = 60,
    parameter int         DIP_HI      = 70,
    parameter int         BUMP_LO     = 82,
    parameter int         BUMP_HI     = 97,
    parameter int         DIP_CNT     = 4,
    parameter int         BUMP_CNT    = 2,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic                    clk,
    input  logic                    rst,
    ir_range_frame_parser_if.slave  bus
);

    localparam int              DCNT_W    = 3;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(NUM_DIGITS - 1);
    localparam int              WW        = DIST_W + 4;

    logic [1:0]        rx_sync_p0;
    logic              byte_stb;
    logic [7:0]        rx_byte;
    rx_state_e         state_p0;
    logic [DIST_W-1:0] acc_p0;
    logic [DCNT_W-1:0] dcnt_p0;
    logic [DIST_W-1:0] distance_p0;
    logic              vld_p0;
    logic              frame_err_p0;
    logic [1:0]        flag_p0;
    logic              timeout;
    logic              dip_hit;
    logic              bump_hit;

    // acc*10 + digit, clamped to the largest DIST_W value.
    function automatic logic [DIST_W-1:0] acc_step(input logic [DIST_W-1:0] acc,
                                                   input logic [7:0]        b);
        logic [WW-1:0] wide;
        wide = (WW'(acc) * WW'(10)) + WW'(b - ASCII_0);
        if (wide > WW'({DIST_W{1'b1}}))
            return '1;
        else
            return wide[DIST_W-1:0];
    endfunction

    assign rx_byte = bus.rx_data;

    // rx_int edge detector; a byte is taken on the falling edge of the level.
    always_ff @(posedge clk) begin
        if (rst)
            rx_sync_p0 <= 2'b00;
        else
            rx_sync_p0 <= {rx_sync_p0[0], bus.rx_int};
    end

    assign byte_stb = rx_sync_p0[1] & ~rx_sync_p0[0];

`ifdef IR_RX_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] tmr_p0;

    assign timeout = (state_p0 != ST_IDLE) && !byte_stb && (tmr_p0 == TMR_LAST);

    // Inter-byte timer: restarts on every byte, idles at zero outside a frame.
    always_ff @(posedge clk) begin
        if (rst || byte_stb || (state_p0 == ST_IDLE) || timeout)
            tmr_p0 <= '0;
        else
            tmr_p0 <= tmr_p0 + TMR_W'(1);
    end
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    logic [31:0] timeout_cyc_unused;
    assign timeout_cyc_unused = 32'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
`endif

    // Frame FSM with registered distance, dist_valid and frame_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= ST_IDLE;
            acc_p0       <= '0;
            dcnt_p0      <= '0;
            distance_p0  <= '0;
            vld_p0       <= 1'b0;
            frame_err_p0 <= 1'b0;
        end else begin
            vld_p0       <= 1'b0;
            frame_err_p0 <= 1'b0;
            if (timeout) begin
                state_p0     <= ST_IDLE;
                frame_err_p0 <= 1'b1;
            end else if (byte_stb) begin
                case (state_p0)
                    ST_IDLE: begin
                        if (rx_byte == HDR0)
                            state_p0 <= ST_GOT_H0;
                    end
                    ST_GOT_H0: begin
                        if (rx_byte == HDR1)
                            state_p0 <= ST_GOT_H1;
                        else if (rx_byte == HDR0)
                            state_p0 <= ST_GOT_H0;
                        else
                            state_p0 <= ST_IDLE;
                    end
                    ST_GOT_H1: begin
                        if (rx_byte == HDR2) begin
                            state_p0 <= ST_DIGITS;
                            acc_p0   <= '0;
                            dcnt_p0  <= '0;
                        end else if (rx_byte == HDR0) begin
                            state_p0 <= ST_GOT_H0;
                        end else begin
                            state_p0 <= ST_IDLE;
                        end
                    end
                    ST_DIGITS: begin
                        if (is_digit(rx_byte)) begin
                            if (dcnt_p0 == DCNT_LAST) begin
                                distance_p0 <= acc_step(acc_p0, rx_byte);
                                vld_p0      <= 1'b1;
                                state_p0    <= ST_IDLE;
                            end else begin
                                acc_p0  <= acc_step(acc_p0, rx_byte);
                                dcnt_p0 <= dcnt_p0 + DCNT_W'(1);
                            end
                        end else begin
                            frame_err_p0 <= 1'b1;
                            state_p0     <= (rx_byte == HDR0) ? ST_GOT_H0 : ST_IDLE;
                        end
                    end
                    default: state_p0 <= ST_IDLE;
                endcase
            end
        end
    end

    ir_persist_filter #(
        .LO (DIP_LO),
        .HI (DIP_HI),
        .CNT(DIP_CNT),
        .W  (DIST_W)
    ) u_dip (
        .clk  (clk),
        .rst  (rst),
        .upd  (vld_p0),
        .clr  (timeout),
        .value(distance_p0),
        .hit  (dip_hit)
    );

    ir_persist_filter #(
        .LO (BUMP_LO),
        .HI (BUMP_HI),
        .CNT(BUMP_CNT),
        .W  (DIST_W)
    ) u_bump (
        .clk  (clk),
        .rst  (rst),
        .upd  (vld_p0),
        .clr  (timeout),
        .value(distance_p0),
        .hit  (bump_hit)
    );

    // Classification flag, registered alongside the persistence counters; bump wins.
    always_ff @(posedge clk) begin
        if (rst)
            flag_p0 <= FLAG_FLAT;
        else if (bump_hit)
            flag_p0 <= FLAG_BUMP;
        else if (dip_hit)
            flag_p0 <= FLAG_DIP;
        else
            flag_p0 <= FLAG_FLAT;
    end

    assign bus.distance   = distance_p0;
    assign bus.dist_valid = vld_p0;
    assign bus.frame_err  = frame_err_p0;
    assign bus.flag_tu_ao = flag_p0;

endmodule
